// File: rtl/watchdog_pkg.sv
// rtl/watchdog_pkg.sv - shared types and constants for the result unloader
package watchdog_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESENT      = 2'd1,
        S_WAIT_RELEASE = 2'd2
    } unloader_state_t;

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - multi-flop synchronizer for an asynchronous input pin
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (ena) begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - unloads a 32-bit result as four bytes over a four-phase pin handshake
module result_unloader
    import watchdog_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic signed [31:0] result,
    input  logic               result_valid,
    input  logic               host_ack,
    output logic [7:0]         out_pins,
    output logic               out_valid,
    output logic               out_last,
    output logic               unloader_busy,
    output logic               frame_done,
    output logic               timeout_err,
    output logic               overrun_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    unloader_state_t  state;
    logic [31:0]      hold;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] cnt;
    logic             frame_done_q;
    logic             ack_s;

    pin_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (host_ack),
        .q     (ack_s)
    );

    // Ack edges are tested before the timeout so a late but valid handshake still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hold         <= '0;
            byte_idx     <= '0;
            cnt          <= '0;
            frame_done_q <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else if (ena) begin
            frame_done_q <= 1'b0;
            if (result_valid && state != S_IDLE) begin
                overrun_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (result_valid) begin
                        hold        <= $unsigned(result);
                        byte_idx    <= '0;
                        cnt         <= '0;
                        timeout_err <= 1'b0;
                        state       <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (ack_s) begin
                        cnt   <= '0;
                        state <= S_WAIT_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!ack_s) begin
                        cnt <= '0;
                        if (byte_idx == LAST_BYTE_IDX) begin
                            frame_done_q <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= S_PRESENT;
                        end
                    end else if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_valid     = (state == S_PRESENT);
    assign out_pins      = select_byte(hold, byte_idx);
    assign out_last      = out_valid && (byte_idx == LAST_BYTE_IDX);
    assign unloader_busy = (state != S_IDLE);
    assign frame_done    = frame_done_q & ena;

endmodule
